alu_share_arbiter: RTL and testbench

- Shares one combinational ALU between two requesters.
  - Port 0: pipeline EX stage, high priority.
  - Port 1: auxiliary requester (branch-target/address calc, debug), low priority.
- Arbitrates with valid/ready handshakes and drives the shared ALU's operand and control inputs.
- Captures the ALU result into a one-deep output register with backpressure; the register is tagged with the source port.
- Sits between the EX-stage operand muxes and the shared ALU.

---
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU, with a one-deep tagged result
// register. Port 0 has priority; port 1 is forced through after STARVE_LIMIT losses in a row.
module alu_share_arbiter #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ct,
  input  logic [WIDTH-1:0] alu_result,

  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_src,
  output logic             res_err
);

  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101: op_legal = 1'b1;
      default:                                                      op_legal = 1'b0;
    endcase
  endfunction

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_src_q, res_src_d;
  logic             res_err_q, res_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             can_accept;
  logic             gnt_vld;
  logic             gnt_sel;
  logic             hs;
  logic             op_ok;

  // Grant selection; reset suppresses every grant so nothing reaches the ALU that cycle.
  always_comb begin
    can_accept = !res_valid_q || res_ready;
    gnt_vld    = 1'b0;
    gnt_sel    = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_sel = (cnt_q == StarveMax);
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
        gnt_sel = 1'b0;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_sel = 1'b1;
      end
    end
    hs = gnt_vld && can_accept;
  end

  always_comb begin
    req0_ready = hs && !gnt_sel;
    req1_ready = hs && gnt_sel;
    alu_a      = '0;
    alu_b      = '0;
    alu_ct     = 4'b0000;
    if (hs) begin
      if (gnt_sel) begin
        alu_a  = req1_a;
        alu_b  = req1_b;
        alu_ct = req1_op;
      end else begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_ct = req0_op;
      end
    end
    op_ok = op_legal(alu_ct);
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_src_d   = res_src_q;
    res_err_d   = res_err_q;
    cnt_d       = cnt_q;
    if (hs) begin
      res_valid_d = 1'b1;
      res_data_d  = op_ok ? alu_result : '0;
      res_src_d   = gnt_sel;
      res_err_d   = !op_ok;
      // Count only port-0 wins that actually made port 1 wait.
      if (!gnt_sel && req1_valid) begin
        if (cnt_q != StarveMax) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_src_q   <= 1'b0;
      res_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_src_q   <= res_src_d;
      res_err_q   <= res_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_src   = res_src_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a cycle-level reference model predicts grants and
// pushes expected results; a separate monitor pops them as the consumer takes each result.
module tb_alu_share_arbiter;

  localparam int W  = 32;
  localparam int SL = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_ct;
  logic         res_valid, res_src, res_err;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .STARVE_LIMIT(SL), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ct(alu_ct), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_src(res_src),
    .res_err(res_err)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         s;
    logic         e;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   m_full = 1'b0;
  int   m_starve = 0;
  int   dut_g;

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};
  endfunction

  function automatic logic [W-1:0] golden(input logic [W-1:0] a, b, input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1101: return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Shared ALU stand-in; garbage on illegal codes so the DUT must zero them itself.
  always_comb alu_result = legal(alu_ct) ? golden(alu_a, alu_b, alu_ct) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus, then a check of the combinational side against the model.
  task automatic step(input logic rst, input logic v0, input logic [W-1:0] a0, b0,
                      input logic [3:0] o0, input logic v1, input logic [W-1:0] a1, b1,
                      input logic [3:0] o1, input logic rr);
    int g;
    logic [W-1:0] ea, eb;
    logic [3:0] eo;
    @(posedge clk);
    #1;
    reset = rst; res_ready = rr;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    @(negedge clk);
    g = -1;
    if (!rst && (!m_full || rr)) begin
      if (v0 && v1) g = (m_starve >= SL) ? 1 : 0;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    chk("req0_ready", req0_ready, (g == 0));
    chk("req1_ready", req1_ready, (g == 1));
    ea = '0; eb = '0; eo = '0;
    if (g == 0) begin ea = a0; eb = b0; eo = o0; end
    if (g == 1) begin ea = a1; eb = b1; eo = o1; end
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_ct", alu_ct, eo);
    chk("res_valid", res_valid, m_full);
    dut_g = req1_ready ? 1 : (req0_ready ? 0 : -1);
    if (rst) begin
      m_full = 1'b0; m_starve = 0; q.delete();
    end else if (g >= 0) begin
      q.push_back('{d: legal(eo) ? golden(ea, eb, eo) : '0, s: (g == 1), e: !legal(eo)});
      m_full = 1'b1;
      if (g == 0 && v1) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
      else              m_starve = 0;
    end else if (rr) begin
      m_full = 1'b0;
    end
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, '0, '0, 4'b0, 1'b0, '0, '0, 4'b0, rr);
  endtask

  always @(negedge clk) begin
    if (!reset && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard: result %0h presented, expected none", res_data);
      end else begin
        mon_e = q.pop_front();
        chk("res_data", res_data, mon_e.d);
        chk("res_src", res_src, mon_e.s);
        chk("res_err", res_err, mon_e.e);
      end
    end
  end

  logic [3:0]   legal_ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};
  int           pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  logic [W-1:0] hold;

  function automatic logic [3:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 4'($urandom);
    return legal_ops[$urandom_range(0, 6)];
  endfunction

  initial begin
    // Reset then idle
    step(1'b1, 1'b0, '0, '0, 4'b0, 1'b0, '0, '0, 4'b0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 4'b0, 1'b0, '0, '0, 4'b0, 1'b0);
    idle(1'b0);
    chk("reset_res_data", res_data, '0);

    // Single port 0: 5 - 3
    step(1'b0, 1'b1, 32'd5, 32'd3, 4'b0110, 1'b0, '0, '0, 4'b0, 1'b1);
    idle(1'b1);
    chk("sub_data", res_data, 32'd2);
    chk("sub_src", res_src, 1'b0);
    chk("sub_err", res_err, 1'b0);
    idle(1'b1);

    // Contention with starvation relief
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, $urandom, $urandom, legal_ops[$urandom_range(0, 6)],
           1'b1, 32'd7, 32'd8, 4'b0010, 1'b1);
      chk("grant_order", dut_g, pat[i]);
      if (i > 0 && pat[i-1] == 1) begin
        chk("port1_add", res_data, 32'd15);
        chk("port1_src", res_src, 1'b1);
      end
    end
    idle(1'b1);

    // Backpressure
    step(1'b0, 1'b1, 32'd10, 32'd20, 4'b0010, 1'b0, '0, '0, 4'b0, 1'b0);
    hold = 32'd30;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'd1, 32'd2, 4'b0001, 1'b0, '0, '0, 4'b0, 1'b0);
      chk("hold_data", res_data, hold);
    end
    step(1'b0, 1'b1, 32'd1, 32'd2, 4'b0001, 1'b0, '0, '0, 4'b0, 1'b1);
    idle(1'b1);
    chk("b2b_valid", res_valid, 1'b1);
    chk("b2b_data", res_data, 32'd3);
    idle(1'b1);

    // Signed compare and illegal op
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0111, 1'b0, '0, '0, 4'b0, 1'b1);
    step(1'b0, 1'b1, 32'd9, 32'd9, 4'b0011, 1'b0, '0, '0, 4'b0, 1'b1);
    chk("slt_data", res_data, 32'd1);
    idle(1'b1);
    chk("illegal_data", res_data, '0);
    chk("illegal_err", res_err, 1'b1);
    idle(1'b1);

    // Reset mid-stream with counter at 3 and a result pending
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'd1, 32'd1, 4'b0010, 1'b1, 32'd2, 32'd2, 4'b0010, 1'b1);
    step(1'b1, 1'b1, 32'd1, 32'd1, 4'b0010, 1'b1, 32'd2, 32'd2, 4'b0010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'd1, 32'd1, 4'b0010, 1'b1, 32'd2, 32'd2, 4'b0010, 1'b1);
      chk("post_reset_grant", dut_g, 0);
    end
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), $urandom, $urandom,
           rand_op(), ($urandom_range(0, 1) == 1), $urandom, $urandom, rand_op(),
           ($urandom_range(0, 9) < 7));
    end

    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
